// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequential initiator for a 32-bit combinational ALU.
// Takes a request (funct, a, b) over valid/ready, drives registered operands and
// function code to the ALU, lets the ALU settle for SETTLE cycles, then returns
// the captured result over a valid/ready response channel with zero/error flags.
//
// Ports:
//   clk, rst                     clock (rising edge), async active-high reset
//   req_valid/req_ready          request handshake
//   req_funct, req_a, req_b      R-type funct code and operands
//   alu_dataA/B, alu_Signal      registered ALU operands and function code
//   alu_dataOut                  combinational ALU result
//   rsp_valid/rsp_ready          response handshake
//   rsp_data, rsp_zero, rsp_err  captured result, result==0, unsupported funct
//   op_count                     responses accepted, wraps modulo 2^CNT_W
module alu_issue_ctrl #(
  parameter int unsigned SETTLE = 2,  // 1..15
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_funct,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic [31:0]      alu_dataA,
  output logic [31:0]      alu_dataB,
  output logic [5:0]       alu_Signal,
  input  logic [31:0]      alu_dataOut,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

  localparam logic [3:0] CntLoad = 4'(SETTLE - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [5:0]        sig_q, sig_d;
  logic [31:0]       data_q, data_d;
  logic              zero_q, zero_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  op_cnt_q, op_cnt_d;
  logic              funct_ok;

  always_comb begin
    funct_ok = 1'b0;
    case (req_funct)
      6'h24, 6'h25, 6'h20, 6'h22, 6'h2A: funct_ok = 1'b1;
      default:                           funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sig_d    = sig_q;
    data_d   = data_q;
    zero_d   = zero_q;
    err_d    = err_q;
    op_cnt_d = op_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (funct_ok) begin
            a_d     = req_a;
            b_d     = req_b;
            sig_d   = req_funct;
            cnt_d   = CntLoad;
            state_d = StSettle;
          end else begin
            // Unsupported funct: answer immediately, leave the ALU inputs alone.
            data_d  = 32'h0;
            zero_d  = 1'b1;
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StSettle: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          data_d  = alu_dataOut;
          zero_d  = (alu_dataOut == 32'h0);
          err_d   = 1'b0;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          op_cnt_d = op_cnt_q + CNT_W'(1);
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      sig_q    <= 6'h0;
      data_q   <= 32'h0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      op_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sig_q    <= sig_d;
      data_q   <= data_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      op_cnt_q <= op_cnt_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign rsp_valid  = (state_q == StResp);
  assign alu_dataA  = a_q;
  assign alu_dataB  = b_q;
  assign alu_Signal = sig_q;
  assign rsp_data   = data_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;
  assign op_count   = op_cnt_q;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequential initiator for the 32-bit combinational ALU datapath (AND/OR/ADD/SUB/SLT, 6-bit function-code select).
- Accepts a request (funct, operand A, operand B) over a valid/ready handshake and drives registered operands and function code to the ALU.
- Waits a programmable number of settle cycles to cover the ripple-carry path, captures the ALU result and returns it over a valid/ready response handshake with zero/error flags.
- Sits between the decode/test-driver logic and the ALU instance.

Parameters:
- SETTLE, 2, cycles the ALU inputs are held stable before the result is sampled; legal range 1..15.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_funct  input  6  MIPS R-type funct code.
- req_a  input  32  operand A.
- req_b  input  32  operand B.
- alu_dataA  output  32  registered operand A to ALU.
- alu_dataB  output  32  registered operand B to ALU.
- alu_Signal  output  6  registered function code to ALU.
- alu_dataOut  input  32  ALU result (combinational from the outputs above).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_data  output  32  captured result.
- rsp_zero  output  1  rsp_data == 0.
- rsp_err  output  1  request funct was unsupported.
- op_count  output  CNT_W  number of responses accepted (rsp_valid & rsp_ready), wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, immediate): state IDLE; req_ready=1; rsp_valid=0; rsp_data=0; rsp_zero=0; rsp_err=0; alu_dataA=0; alu_dataB=0; alu_Signal=0; op_count=0; settle counter=0.
- Supported funct: 6'h24 AND, 6'h25 OR, 6'h20 ADD, 6'h22 SUB, 6'h2A SLT. All others are unsupported.
- FSM states: IDLE, SETTLE, RESP.
- IDLE: req_ready=1.
  - On req_valid, supported funct: latch req_a/req_b/req_funct into alu_dataA/alu_dataB/alu_Signal, load counter with SETTLE-1, go to SETTLE.
  - On req_valid, unsupported funct: do not touch the ALU outputs; set rsp_data=0, rsp_zero=1, rsp_err=1, rsp_valid=1, go to RESP.
- SETTLE: req_ready=0; ALU outputs held constant.
  - Counter>0: decrement.
  - Counter==0: capture alu_dataOut into rsp_data, rsp_zero=(alu_dataOut==0), rsp_err=0, rsp_valid=1, go to RESP.
- Latency: request accept edge to rsp_valid high is SETTLE+1 rising edges for supported ops, and 1 edge for unsupported ops.
- RESP: req_ready=0; rsp_* stable while rsp_valid & !rsp_ready.
  - On rsp_ready: rsp_valid=0, op_count++, go to IDLE. The next request is accepted no earlier than the following cycle, so there is no same-cycle turnaround.
- ALU output registers retain their last values after the response; they change only on the next supported accept.
- SLT returns 32'h0000_0001 or 0, exactly as produced by the ALU (unsigned compare). This block does no arithmetic of its own.
- rsp_ready while rsp_valid=0 is ignored. req_valid while req_ready=0 is ignored; the requester must hold the request until it is accepted.
- op_count wraps from all-ones to 0 without a flag.
- Reset asserted in SETTLE or RESP aborts the operation. No response is produced and all outputs take their reset values.

Test Plan:
- After reset, req ADD a=32'h0000_0005 b=32'h0000_0003 with rsp_ready=1 -> alu_Signal=6'h20 held SETTLE cycles; rsp_data=32'h0000_0008, rsp_zero=0, rsp_err=0 exactly 3 edges after accept; op_count=1.
- SUB a=7 b=7, then SLT a=2 b=9 -> rsp_data=0 with rsp_zero=1; then rsp_data=1 with rsp_zero=0; req_ready low throughout each operation.
- Unsupported funct 6'h18 a=32'hFFFF_FFFF -> rsp_valid 1 edge after accept; rsp_err=1, rsp_data=0; alu_dataA unchanged from the previous op.
- Backpressure: AND a=32'hF0F0_F0F0 b=32'hFF00_FF00 with rsp_ready=0 for 5 cycles -> rsp_data=32'hF000_F000 stable; req_ready=0; a second req_valid is ignored; op_count increments only on the ready cycle.
- Assert rst mid-SETTLE during OR -> all outputs reset asynchronously before the next edge; no rsp_valid; next request processes normally.
- Force op_count to all-ones by 2^CNT_W accepts (CNT_W=4 override: 16 ops) -> op_count wraps to 0.
